// File: rtl/ysyx_22050854_ifu.sv
// Instruction fetch unit: one outstanding imem request, holds one fetched
// word for decode, and handles redirects, sticky halt and stale responses.
module ysyx_22050854_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic [63:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        halt_q, halt_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] ipc_q, ipc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      halt_q  <= 1'b0;
      cnt_q   <= 64'd0;
      instr_q <= 32'h0;
      ipc_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    halt_d  = halt_q | halt;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) pc_d = redirect_pc;
        // an accepted request always completes; redirect marks it stale
        if (imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end else if (halt_d) begin
          state_d = S_HALTED;
        end
      end
      S_WAIT: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (redirect_valid || drop_q) begin
            state_d = S_REQ;
          end else begin
            state_d = S_HOLD;
            instr_d = imem_rdata;
            ipc_d   = pc_q;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (id_ready) begin
          pc_d    = pc_q + 64'd4;
          cnt_d   = cnt_q + 64'd1;
          state_d = halt_d ? S_HALTED : S_REQ;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
    endcase
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign id_valid       = (state_q == S_HOLD);
  assign id_instr       = instr_q;
  assign id_pc          = ipc_q;
  assign fetch_cnt      = cnt_q;

endmodule
